// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multicycle execute unit with a serial 1-bit-per-cycle shifter
module multicycle_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   operation_valid,
    output logic                   operation_ready,
    input  logic [3:0]             alu_control_code,
    input  logic [DATA_WIDTH-1:0]  operand_a,
    input  logic [DATA_WIDTH-1:0]  operand_b,
    input  logic [TAG_WIDTH-1:0]   operation_tag,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   result_zero,
    output logic [TAG_WIDTH-1:0]   result_tag,
    output logic                   busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_LUI  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_zero;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic [SHAMT_WIDTH-1:0]  r_count;
    logic                    r_shift_right;
    logic                    r_shift_arith;

    logic                    w_accept;
    logic                    w_is_shift;
    logic                    w_start_shift;
    logic                    w_last_shift;
    logic [SHAMT_WIDTH-1:0]  w_shamt;
    logic [DATA_WIDTH-1:0]   w_alu_result;
    logic [DATA_WIDTH-1:0]   w_shift_next;

    assign operation_ready = (r_state == S_IDLE) && rst_n;
    assign busy            = (r_state != S_IDLE);
    assign result_valid    = (r_state == S_DONE);
    assign result          = r_result;
    assign result_zero     = r_zero;
    assign result_tag      = r_tag;

    // flush wins over accept, so a flushed request is never captured
    assign w_accept      = operation_valid && operation_ready && !flush;
    assign w_shamt       = operand_b[SHAMT_WIDTH-1:0];
    assign w_is_shift    = (alu_control_code == OP_SLL) || (alu_control_code == OP_SRL) ||
                           (alu_control_code == OP_SRA);
    assign w_start_shift = w_accept && w_is_shift && (w_shamt != '0);
    assign w_last_shift  = (r_count == SHAMT_WIDTH'(1));

    // single-cycle result; a zero-amount shift simply passes operand_a
    always_comb begin
        w_alu_result = operand_a + operand_b;
        case (alu_control_code)
            OP_SUB:  w_alu_result = operand_a - operand_b;
            OP_SLT:  w_alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, (operand_a < operand_b)};
            OP_XOR:  w_alu_result = operand_a ^ operand_b;
            OP_OR:   w_alu_result = operand_a | operand_b;
            OP_AND:  w_alu_result = operand_a & operand_b;
            OP_LUI:  w_alu_result = operand_b;
            OP_SLL, OP_SRL, OP_SRA: w_alu_result = operand_a;
            default: w_alu_result = operand_a + operand_b;
        endcase
    end

    // one-bit step of the serial shifter; the result register doubles as the shift register
    always_comb begin
        w_shift_next = {r_result[DATA_WIDTH-2:0], 1'b0};
        if (r_shift_right) begin
            w_shift_next = {(r_shift_arith & r_result[DATA_WIDTH-1]), r_result[DATA_WIDTH-1:1]};
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state logic
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next_state = w_start_shift ? S_SHIFT : S_DONE;
                S_SHIFT: if (w_last_shift) w_next_state = S_DONE;
                S_DONE:  if (result_ready) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // datapath: capture on accept, shift while in SHIFT, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result      <= '0;
            r_zero        <= 1'b1;
            r_tag         <= '0;
            r_count       <= '0;
            r_shift_right <= 1'b0;
            r_shift_arith <= 1'b0;
        end else if (!flush) begin
            if (w_accept) begin
                r_tag         <= operation_tag;
                r_shift_right <= alu_control_code[2];
                r_shift_arith <= alu_control_code[3];
                r_count       <= w_shamt;
                r_result      <= w_alu_result;
                if (!w_start_shift) begin
                    r_zero <= (w_alu_result == '0);
                end
            end else if (r_state == S_SHIFT) begin
                r_result <= w_shift_next;
                r_count  <= r_count - SHAMT_WIDTH'(1);
                if (w_last_shift) begin
                    r_zero <= (w_shift_next == '0);
                end
            end
        end
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Area-optimised execute unit that consumes the 4-bit `alu_control_code` produced by the ALU control decoder, together with two operands, and returns a registered result through valid/ready handshakes. Add, subtract, logic, compare and LUI complete in one cycle. Shifts use a serial 1-bit-per-cycle shifter instead of a barrel shifter. It sits in the EX stage between operand forwarding and the EX/MEM register, and the pipeline stalls on `operation_ready`/`result_valid`.

## Interface
- `DATA_WIDTH`, 32: operand/result width.
- `SHAMT_WIDTH`, 5: shift-amount bits taken from `operand_b` (log2 of `DATA_WIDTH`).
- `TAG_WIDTH`, 5: sideband tag (destination register) carried alongside the operation.
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `flush`  input  1  abort any accepted or in-flight operation.
- `operation_valid`  input  1  new operation offered.
- `operation_ready`  output  1  unit can accept an operation this cycle.
- `alu_control_code`  input  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, LUI 1001.
- `operand_a`, `operand_b`  input  DATA_WIDTH  source operands.
- `operation_tag`  input  TAG_WIDTH  sideband, returned unchanged.
- `result_valid`  output  1  result, zero flag and tag are valid.
- `result_ready`  input  1  consumer takes the result.
- `result`  output  DATA_WIDTH  registered result.
- `result_zero`  output  1  `result == 0` (used for BEQ/BNE); registered with `result`.
- `result_tag`  output  TAG_WIDTH  tag of the completed operation.
- `busy`  output  1  state is not IDLE.

## Operation
- FSM states are IDLE, SHIFT and DONE. `operation_ready = (state == IDLE) && rst_n`. `busy = (state != IDLE)`.
- Accept happens when `operation_valid && operation_ready`. On accept the unit captures the code, operands and tag.
- Single-cycle codes, on accept:
  - ADD is a+b and SUB is a−b, both modulo 2^DATA_WIDTH with carry discarded.
  - SLT is a signed compare and SLTU an unsigned compare; each produces 1 or 0, zero-extended.
  - XOR, OR and AND are bitwise.
  - LUI passes `operand_b` through.
  - Result registers load and the FSM goes IDLE→DONE.
- Any undefined code is executed as ADD.
- Shift codes (SLL, SRL, SRA): shamt = `operand_b[SHAMT_WIDTH-1:0]`, upper bits ignored.
  - shamt=0: result = `operand_a`, IDLE→DONE.
  - shamt>0: the shift register loads `operand_a`, the counter loads shamt, and the FSM goes IDLE→SHIFT.
  - In SHIFT, each cycle shifts 1 bit and decrements the counter. SLL fills with 0, SRL fills with 0, SRA replicates the MSB.
  - The cycle the counter goes 1→0 performs the final shift and moves to DONE.
- DONE: `result_valid=1`. `result`, `result_zero` and `result_tag` hold stable until `result_valid && result_ready`, then DONE→IDLE.
- `result_zero` is computed from the final result value, registered with it.
- `flush=1` in any state sends the FSM to IDLE on the next edge and discards any accept in the same cycle. `flush` has priority over accept, shift and handshake. Result registers need not clear, but `result_valid` must be 0 the next cycle.
- Reset (`rst_n=0` at an edge) overrides everything, including mid-shift. Its effect is defined in Timing.

## Timing
- Reset values: state IDLE, `result`=0, `result_zero`=1, `result_tag`=0, `result_valid`=0, `busy`=0. `operation_ready`=0 while `rst_n`=0 and 1 on the first cycle after release.
- Latency is counted from the accept edge to the first `result_valid` high.
  - Non-shift ops and zero-shift ops: 1 cycle.
  - Shift by N≥1: N+1 cycles (one edge to enter SHIFT, N shift edges, DONE visible after the last).
- Throughput: `operation_ready` is low throughout SHIFT and DONE. There is no accept in the cycle a result is handed off; the next accept is possible one cycle after the handoff edge.
- Backpressure: `result_valid` stays high indefinitely while `result_ready`=0, and outputs must not change.
- `result_ready` while `result_valid`=0 is ignored. `operation_valid` while not ready is ignored; the unit latches nothing.
- Simultaneous `flush` and handoff in DONE: the next state is IDLE either way, and the handoff counts as consumed.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → after 1 cycle `result`=0x80000000, `result_zero`=0. Then SUB a=b=0x1234 → `result`=0, `result_zero`=1.
- SLT a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0. LUI b=0xABCDE000 → 0xABCDE000. Code 1111 with a=2, b=3 → 5.
- SRA a=0x80000000, b=0x0000003F (shamt 31) → `result_valid` 32 cycles after accept, `result`=0xFFFFFFFF. SRL with the same operands → 0x00000001. SLL with b=0 → `operand_a` after 1 cycle.
- Backpressure: XOR completes with `result_ready`=0 for 5 cycles → `result`, `result_tag` and `result_valid` stable, `operation_ready`=0. When ready rises, the next operation is accepted the following cycle.
- `flush` on the 4th cycle of an SLL by 20 → IDLE next cycle, `result_valid` never asserts for that op, and a subsequent AND 0xF0F0&0xFF00 returns 0xF000 with its own tag.
- `rst_n`=0 mid-SRL by 10 → all outputs at reset values after the edge. After release, `operation_ready`=1 and a fresh ADD 1+1 → 2 after 1 cycle.
